// File: rtl/pla_eval_pkg.sv
// Shared types and constants for the PLA equivalence sweeper.
// Holds the FSM state encoding and the sweep end-point helper.
package pla_eval_pkg;

  localparam int N_IN_DEF   = 9;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  function automatic int vec_last(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/pla_vec_gen.sv
// Vector index counter plus settle timer for the equivalence sweep.
// Emits a one-cycle sample strobe and flags the final vector.
module pla_vec_gen
  import pla_eval_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            run,
  output logic [N_IN-1:0] vec,
  output logic            sample_en,
  output logic            last
);

  localparam logic [N_IN:0] LAST = (N_IN+1)'(vec_last(N_IN));
  localparam logic [3:0]    SET  = 4'(SETTLE_CYC);

  logic [N_IN:0] idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;

  always_comb begin
    sample_en = run && (cnt_q == SET);
    last      = sample_en && (idx_q == LAST);
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    if (clear) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (sample_en) begin
      // the final vector stays on the bus after the sweep ends
      if (!last) idx_d = idx_q + 1'b1;
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign vec = idx_q[N_IN-1:0];

endmodule

// File: rtl/pla_equiv_sweeper.sv
// Exhaustive equivalence sweep of a reference and an optimised PLA.
// FSM, output comparator and registered result counters.
module pla_equiv_sweeper
  import pla_eval_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            y_ref,
  input  logic            y_opt,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [N_IN:0]   onset_cnt
);

  state_e state_q, state_d;

  logic            start_ok;
  logic            abort_ok;
  logic            run;
  logic            sample_en;
  logic            last;
  logic            miss;

  logic [N_IN:0]   mism_q, mism_d;
  logic [N_IN:0]   onset_q, onset_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic            pass_q, pass_d;

  assign start_ok = start && (state_q != SWEEP);
  assign abort_ok = abort && (state_q == SWEEP);
  assign run      = (state_q == SWEEP) && !abort;
  assign miss     = y_ref ^ y_opt;

  pla_vec_gen #(
    .N_IN       (N_IN),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .run       (run),
    .vec       (vec),
    .sample_en (sample_en),
    .last      (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    if (start) state_d = SWEEP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mism_d  = mism_q;
    onset_d = onset_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    pass_d  = pass_q;
    if (start_ok) begin
      mism_d  = '0;
      onset_d = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
      pass_d  = 1'b0;
    end else if (sample_en) begin
      if (miss) mism_d = mism_q + 1'b1;
      if (miss && !ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = vec;
      end
      if (y_ref) onset_d = onset_q + 1'b1;
      // verdict includes the final sample's contribution
      if (last) pass_d = (mism_d == '0);
    end else if (abort_ok) begin
      pass_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mism_q  <= '0;
      onset_q <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mism_q  <= mism_d;
      onset_q <= onset_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      pass_q  <= pass_d;
    end
  end

  assign busy             = (state_q == SWEEP);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign mismatch_cnt     = mism_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign onset_cnt        = onset_q;

endmodule

// File: tb/tb_pla_equiv_sweeper.sv
// Scoreboard bench for pla_equiv_sweeper.
// Two instances: default settle and settle of three cycles.
module tb_pla_equiv_sweeper;

  localparam int N = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start3, abort, abort3;
  logic y_ref, y_opt, y_ref3, y_opt3;
  int   mode;

  logic [N-1:0] vec, vec3, ffvec, ffvec3;
  logic         busy, done, pass, ffv;
  logic         busy3, done3, pass3, ffv3;
  logic [N:0]   mism, onset, mism3, onset3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int mism;
    int onset;
    int ffv;
    int ffvec;
    int pass;
    int lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic f_ref(int m, logic [N-1:0] v);
    if (m == 2) return 1'b1;
    return ^v;
  endfunction

  function automatic logic f_opt(int m, logic [N-1:0] v);
    if (m == 2) return 1'b0;
    if (m == 1) return (^v) ^ (v == 9'd37);
    return ^v;
  endfunction

  always_comb begin
    y_ref  = f_ref(mode, vec);
    y_opt  = f_opt(mode, vec);
    y_ref3 = f_ref(mode, vec3);
    y_opt3 = f_opt(mode, vec3);
  end

  pla_equiv_sweeper #(.N_IN(N), .SETTLE_CYC(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .vec              (vec),
    .y_ref            (y_ref),
    .y_opt            (y_opt),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_cnt     (mism),
    .first_fail_valid (ffv),
    .first_fail_vec   (ffvec),
    .onset_cnt        (onset)
  );

  pla_equiv_sweeper #(.N_IN(N), .SETTLE_CYC(3)) dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start3),
    .abort            (abort3),
    .vec              (vec3),
    .y_ref            (y_ref3),
    .y_opt            (y_opt3),
    .busy             (busy3),
    .done             (done3),
    .pass             (pass3),
    .mismatch_cnt     (mism3),
    .first_fail_valid (ffv3),
    .first_fail_vec   (ffvec3),
    .onset_cnt        (onset3)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(int m, int settle);
    exp_t e;
    logic [N-1:0] v;
    e = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < (1 << N); i++) begin
      v = N'(i);
      if (f_ref(m, v) != f_opt(m, v)) begin
        if (e.ffv == 0) e.ffvec = i;
        e.ffv = 1;
        e.mism++;
      end
      if (f_ref(m, v)) e.onset++;
    end
    e.pass = (e.mism == 0) ? 1 : 0;
    e.lat  = (1 << N) * (settle + 1);
    return e;
  endfunction

  task automatic all_zero(input string tag);
    chk(tag, {vec, busy, done, pass, mism, ffv, ffvec, onset}, 64'd0);
  endtask

  task automatic run_sweep(input int m, input int sel, input int pulse_at);
    exp_t e;
    int   cyc;
    mode = m;
    sb.push_back(model(m, sel ? 3 : 1));
    @(negedge clk);
    if (sel != 0) start3 = 1'b1;
    else          start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start3 = 1'b0;
    chk("busy_on_start", sel ? busy3 : busy, 1);
    chk("vec_on_start", sel ? vec3 : vec, 0);
    chk("done_cleared", sel ? done3 : done, 0);
    cyc = 0;
    while (!(sel ? done3 : done) && cyc < 6000) begin
      if (cyc == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("busy_done", sel ? busy3 : busy, 0);
    chk("mismatch_cnt", sel ? mism3 : mism, e.mism);
    chk("onset_cnt", sel ? onset3 : onset, e.onset);
    chk("ff_valid", sel ? ffv3 : ffv, e.ffv);
    chk("ff_vec", sel ? ffvec3 : ffvec, e.ffvec);
    chk("pass", sel ? pass3 : pass, e.pass);
    chk("vec_last", sel ? vec3 : vec, (1 << N) - 1);
    repeat (3) @(posedge clk);
    #1 chk("done_held", sel ? done3 : done, 1);
  endtask

  initial begin
    exp_t part;
    int   ones;
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    abort  = 1'b0;
    abort3 = 1'b0;
    mode   = 0;
    #12;
    all_zero("reset_state");
    chk("reset_busy3", {busy3, done3, vec3}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 all_zero("idle_after_reset");

    run_sweep(0, 0, -1);
    run_sweep(1, 0, -1);
    run_sweep(2, 0, -1);
    run_sweep(2, 1, -1);
    run_sweep(0, 0, 100);

    // abort lands on edge 300 after start; vectors 0..148 sampled
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (299) @(posedge clk);
    #1 abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    ones = 0;
    for (int i = 0; i < 149; i++) begin
      logic [N-1:0] v;
      v = N'(i);
      if (^v) ones++;
    end
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_vec", vec, 149);
    chk("abort_onset", onset, ones);
    chk("abort_mism", mism, 0);
    repeat (5) @(posedge clk);
    #1 chk("abort_idle", {busy, done}, 0);
    run_sweep(0, 0, -1);

    // asynchronous reset mid-sweep
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (499) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("async_reset");
    repeat (3) @(posedge clk);
    #1 chk("reset_no_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 0, -1);

    part = model(0, 1);
    chk("sb_empty", sb.size(), 0);
    chk("onset_ref_256", part.onset, 256);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
